mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers, placed in the E stage directly downstream of the instruction decoder. Consumes the decoder's 4-bit MDU opcode and `start` strobe plus E-stage rs/rt operands. Exposes `busy` to the hazard unit and a read port for mfhi/mflo. Emulates fixed-latency hardware: 5 cycles for mult, 10 for div.

## Interface
- `MULT_CYCLES`, 5, busy duration for mult/multu
- `DIV_CYCLES`, 10, busy duration for div/divu
- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req`  in  1  exception/interrupt request this cycle; cancels the E-stage MDU instruction presented now
- `start`  in  1  decoder strobe, high for mult/multu/div/divu
- `mdu_op`  in  4  0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mfhi, 0110 mflo, 0111 mthi, 1000 mtlo
- `a`  in  32  rs operand (forwarded)
- `b`  in  32  rt operand (forwarded)
- `busy`  out  1  operation in flight
- `hi`  out  32  HI register
- `lo`  out  32  LO register
- `mdu_rd`  out  32  combinational: HI if mdu_op=mfhi, LO if mflo, else 0

## Operation
- Reset: HI=0, LO=0, busy=0, counter=0, pending results cleared; `mdu_rd`=0 with mdu_op=0000.
- Accept: a start/mthi/mtlo is accepted only when `req`=0 and busy=0. Otherwise ignored. The hazard unit guarantees no MDU instruction reaches E while busy; the ignore rule is the defined fallback.
- mult: {HI,LO} ← signed(a)×signed(b), full 64 bits.
- multu: {HI,LO} ← unsigned product.
- div: LO ← quotient truncated toward zero; HI ← remainder with the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero (b=0): HI/LO unchanged at completion. Busy still runs the full DIV_CYCLES.
- On accept, the result is computed and latched into internal pending registers. HI/LO are not updated until completion.
- mthi/mtlo: HI or LO ← a at the accepting edge. No busy.
- mfhi/mflo: read only, no state change.
- Two states:
  - IDLE → BUSY on an accepted start. Counter loaded with the cycle count.
  - BUSY: counter decrements each cycle. At counter=1, pending values are written to HI/LO and the state returns to IDLE.
- `req` while BUSY does not abort: the in-flight instruction has already committed past M.

## Timing
- Start accepted at edge of cycle T: busy=1 during cycles T+1 … T+N (N=MULT_CYCLES or DIV_CYCLES).
- HI/LO hold the new values from cycle T+N+1. busy=0 in that same cycle.
- A dependent mfhi in E is stalled by the hazard unit on `busy|start`, and reads the correct value in cycle T+N+1.
- Back-to-back: a new start is accepted in cycle T+N+1, with no bubble.
- mthi/mtlo: written at the edge ending cycle T. Visible on `hi`/`lo`/`mdu_rd` in T+1.
- mfhi in the same cycle as mthi reads the old value. The hazard unit must not allow this pairing.
- `req`=1 together with `start`: nothing accepted, busy stays 0, HI/LO unchanged.
- reset during BUSY: next cycle busy=0, HI=LO=0, the pending result is discarded.
- `mdu_rd` is purely combinational from mdu_op and HI/LO, with zero latency.

## Structure
- MDU opcode encodings go in the shared decode header/package as named constants, alongside the decoder's other op encodings. MULT_CYCLES/DIV_CYCLES defaults go there too.
- Single module, no sub-module.
  - 64-bit product via the native `*` on sign-/zero-extended operands.
  - Quotient/remainder via native `/` and `%` with explicit signed casts.
  - One 4-bit down-counter, one state bit, two 32-bit pending registers.

## Test plan
- mult a=0xFFFFFFFE (−2), b=3 → busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu a=0xFFFFFFFF, b=2 → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div a=0xFFFFFFF9 (−7), b=2 → busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Follow with divu on the same operands → LO=0x7FFFFFFC, HI=1.
- div b=0 after mthi 0x1234 / mtlo 0x5678 → busy 10 cycles; HI=0x1234, LO=0x5678 unchanged. mfhi then returns 0x1234 on `mdu_rd`.
- start mult with req=1 → busy never rises, HI/LO unchanged. The same op with req=0 one cycle later is accepted normally.
- Start div, assert reset at busy cycle 4 → next cycle busy=0, HI=LO=0. A new start then accepts normally.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared decode constants for the E-stage multiply/divide unit.
// Holds the MDU opcode encodings, default latencies and the unit's state type.
package mult_div_unit_pkg;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    localparam logic [3:0] MDU_OP_NONE  = 4'b0000;
    localparam logic [3:0] MDU_OP_MULT  = 4'b0001;
    localparam logic [3:0] MDU_OP_MULTU = 4'b0010;
    localparam logic [3:0] MDU_OP_DIV   = 4'b0011;
    localparam logic [3:0] MDU_OP_DIVU  = 4'b0100;
    localparam logic [3:0] MDU_OP_MFHI  = 4'b0101;
    localparam logic [3:0] MDU_OP_MFLO  = 4'b0110;
    localparam logic [3:0] MDU_OP_MTHI  = 4'b0111;
    localparam logic [3:0] MDU_OP_MTLO  = 4'b1000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    function automatic logic mdu_is_arith(input logic [3:0] op);
        return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) ||
               (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed on accept and held pending until the emulated latency expires.
//
// state   | meaning
// ST_IDLE | nothing in flight; start/mthi/mtlo may be accepted
// ST_BUSY | latency countdown; pending result commits when cnt_q is 1
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdu_rd
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    mdu_state_e         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [31:0]        pend_hi_q, pend_lo_q;
    logic               pend_wr_q;

    logic               accept, launch, is_div, commit;
    logic [31:0]        res_hi, res_lo;
    logic               res_wr;
    logic [63:0]        prod_s, prod_u;
    logic signed [31:0] sdiv_a, sdiv_b;
    logic [31:0]        udiv_b;
    logic               div_guard;

    assign accept = (state_q == ST_IDLE) && !req;
    assign launch = accept && start && mdu_is_arith(mdu_op);
    assign is_div = (mdu_op == MDU_OP_DIV) || (mdu_op == MDU_OP_DIVU);

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Zero divisors and INT_MIN/-1 both divide by 1 instead: the latter then
    // yields exactly INT_MIN rem 0, and the former is never committed.
    assign div_guard = (b == 32'd0) || ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
    assign sdiv_a    = $signed(a);
    assign sdiv_b    = div_guard ? 32'sd1 : $signed(b);
    assign udiv_b    = (b == 32'd0) ? 32'd1 : b;

    always_comb begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
        res_wr = 1'b1;
        case (mdu_op)
            MDU_OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MDU_OP_DIV: begin
                res_lo = $unsigned(sdiv_a / sdiv_b);
                res_hi = $unsigned(sdiv_a % sdiv_b);
            end
            MDU_OP_DIVU: begin
                res_lo = a / udiv_b;
                res_hi = a % udiv_b;
            end
            default: ;
        endcase
        if (is_div && (b == 32'd0)) begin
            res_wr = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d = ST_BUSY;
                    cnt_d   = is_div ? DIV_LOAD : MULT_LOAD;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                    commit  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi        <= 32'd0;
            lo        <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            if (launch) begin
                pend_hi_q <= res_hi;
                pend_lo_q <= res_lo;
                pend_wr_q <= res_wr;
            end
            if (commit && pend_wr_q) begin
                hi <= pend_hi_q;
                lo <= pend_lo_q;
            end
            if (accept && (mdu_op == MDU_OP_MTHI)) begin
                hi <= a;
            end
            if (accept && (mdu_op == MDU_OP_MTLO)) begin
                lo <= a;
            end
        end
    end

    assign busy = (state_q == ST_BUSY);

    always_comb begin
        mdu_rd = 32'd0;
        if (mdu_op == MDU_OP_MFHI) begin
            mdu_rd = hi;
        end else if (mdu_op == MDU_OP_MFLO) begin
            mdu_rd = lo;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops
// compared against a 64-bit integer arithmetic model of HI/LO.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdu_rd;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .start  (start),
        .mdu_op (mdu_op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .mdu_rd (mdu_rd)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic on the architectural values.
    task automatic model_arith(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     w;
        sa = longint'($signed(va));
        sb = longint'($signed(vb));
        ua = 64'(va);
        ub = 64'(vb);
        case (op)
            MDU_OP_MULT: begin
                w = sa * sb;
                m_hi = w[63:32];
                m_lo = w[31:0];
            end
            MDU_OP_MULTU: begin
                w = ua * ub;
                m_hi = w[63:32];
                m_lo = w[31:0];
            end
            MDU_OP_DIV: if (vb != 32'd0) begin
                w = sa / sb;
                m_lo = w[31:0];
                w = sa % sb;
                m_hi = w[31:0];
            end
            MDU_OP_DIVU: if (vb != 32'd0) begin
                w = ua / ub;
                m_lo = w[31:0];
                w = ua % ub;
                m_hi = w[31:0];
            end
            default: ;
        endcase
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                         input logic rq, input logic poke);
        logic [31:0] old_hi, old_lo;
        int          expn, nb;
        logic        arith;
        arith = (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) ||
                (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
        @(negedge clk);
        mdu_op = op; a = va; b = vb; req = rq; start = arith;
        @(posedge clk); #1;
        start = 1'b0; req = 1'b0; mdu_op = MDU_OP_NONE; a = $urandom; b = $urandom;
        old_hi = m_hi;
        old_lo = m_lo;
        if (rq) begin
            check_val("req_busy", 32'(busy), 32'd0);
            check_val("req_hi", hi, old_hi);
            check_val("req_lo", lo, old_lo);
            return;
        end
        if (!arith) begin
            if (op == MDU_OP_MTHI) m_hi = va;
            if (op == MDU_OP_MTLO) m_lo = va;
            check_val("mt_busy", 32'(busy), 32'd0);
            check_val("mt_hi", hi, m_hi);
            check_val("mt_lo", lo, m_lo);
            return;
        end
        model_arith(op, va, vb);
        expn = (op == MDU_OP_DIV || op == MDU_OP_DIVU) ? MDU_DIV_CYCLES : MDU_MULT_CYCLES;
        nb = 0;
        while (busy && nb < 40) begin
            if (poke && nb == 1) begin
                mdu_op = MDU_OP_MTHI;
                a = 32'hDEAD_BEEF;
            end else begin
                mdu_op = MDU_OP_NONE;
            end
            if (nb == expn - 1) begin
                check_val("hold_hi", hi, old_hi);
                check_val("hold_lo", lo, old_lo);
            end
            @(posedge clk); #1;
            nb++;
        end
        mdu_op = MDU_OP_NONE;
        check_val("busy_len", 32'(nb), 32'(expn));
        check_val("res_hi", hi, m_hi);
        check_val("res_lo", lo, m_lo);
    endtask

    task automatic rd_chk(input logic [3:0] op);
        logic [31:0] exp;
        @(negedge clk);
        mdu_op = op;
        #1;
        exp = (op == MDU_OP_MFHI) ? m_hi : ((op == MDU_OP_MFLO) ? m_lo : 32'd0);
        check_val("mdu_rd", mdu_rd, exp);
        mdu_op = MDU_OP_NONE;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd0;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] ops [6];
        logic [3:0] op;
        logic [31:0] va, vb;
        ops = '{MDU_OP_MULT, MDU_OP_MULTU, MDU_OP_DIV, MDU_OP_DIVU, MDU_OP_MTHI, MDU_OP_MTLO};

        reset = 1'b1; req = 1'b0; start = 1'b0; mdu_op = MDU_OP_NONE; a = 32'd0; b = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_hi", hi, 32'd0);
        check_val("rst_lo", lo, 32'd0);
        check_val("rst_rd", mdu_rd, 32'd0);

        do_op(MDU_OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        check_val("mult_hi", hi, 32'hFFFF_FFFF);
        check_val("mult_lo", lo, 32'hFFFF_FFFA);
        do_op(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        check_val("multu_hi", hi, 32'h0000_0001);
        check_val("multu_lo", lo, 32'hFFFF_FFFE);
        do_op(MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        check_val("div_hi", hi, 32'hFFFF_FFFF);
        check_val("div_lo", lo, 32'hFFFF_FFFD);
        do_op(MDU_OP_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        check_val("divu_hi", hi, 32'h0000_0001);
        check_val("divu_lo", lo, 32'h7FFF_FFFC);

        do_op(MDU_OP_MTHI, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
        do_op(MDU_OP_MTLO, 32'h0000_5678, 32'd0, 1'b0, 1'b0);
        do_op(MDU_OP_DIV, 32'd99, 32'd0, 1'b0, 1'b0);
        check_val("div0_hi", hi, 32'h0000_1234);
        check_val("div0_lo", lo, 32'h0000_5678);
        rd_chk(MDU_OP_MFHI);
        rd_chk(MDU_OP_MFLO);
        rd_chk(MDU_OP_MULT);

        do_op(MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check_val("ovf_hi", hi, 32'd0);
        check_val("ovf_lo", lo, 32'h8000_0000);

        do_op(MDU_OP_MULT, 32'd7, 32'd6, 1'b1, 1'b0);
        do_op(MDU_OP_MULT, 32'd7, 32'd6, 1'b0, 1'b1);
        do_op(MDU_OP_MTHI, 32'h0BAD_0BAD, 32'd0, 1'b1, 1'b0);

        @(negedge clk);
        mdu_op = MDU_OP_DIV; start = 1'b1; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; mdu_op = MDU_OP_NONE;
        repeat (3) @(posedge clk);
        #1;
        check_val("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_hi", hi, 32'd0);
        check_val("mid_rst_lo", lo, 32'd0);
        repeat (8) @(posedge clk);
        #1;
        check_val("post_rst_hi", hi, 32'd0);
        check_val("post_rst_busy", 32'(busy), 32'd0);
        do_op(MDU_OP_MULT, 32'd12345, 32'hFFFF_0000, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 5)];
            va = pick();
            vb = pick();
            do_op(op, va, vb, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) rd_chk(MDU_OP_MFHI);
            if ($urandom_range(0, 2) == 0) rd_chk(MDU_OP_MFLO);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
